// File: rtl/noise_voice_sched.sv
// Round-robin scheduler sharing one 62-bit LFSR noise generator between NVOICE voices.
// Optional feature: define NOISE_SCHED_PRIO_EN to make voice 0 a fixed highest-priority requester.
module noise_voice_sched #(
    parameter int          NVOICE = 4,
    parameter int          DSZ    = 18,
    parameter int          STEPS  = 18,
    parameter logic [61:0] SEED   = 62'h36587D435AA26465
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NVOICE-1:0]    req,
    output logic [NVOICE-1:0]    ack,
    output logic [DSZ-1:0]       sample,
    output logic [$clog2(NVOICE)-1:0] sample_vid,
    output logic                 busy
);

    localparam int IDW = $clog2(NVOICE);
    localparam int CW  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [61:0]       sr_q, sr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [NVOICE-1:0] ack_q, ack_d;
    logic [DSZ-1:0]    sample_q, sample_d;
    logic [IDW-1:0]    vid_q, vid_d;

    logic              pick_found;
    logic [IDW-1:0]    pick;
    logic              fb;

    assign fb = sr_q[61] ^ sr_q[60] ^ sr_q[5] ^ sr_q[4];

    // Arbitration: first requesting voice after the most recently served one.
`ifdef NOISE_SCHED_PRIO_EN
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        if (req[0]) begin
            pick_found = 1'b1;
        end else begin
            for (int i = 1; i < NVOICE; i++) begin
                int idx;
                idx = ((int'(last_q) - 1 + i) % (NVOICE - 1)) + 1;
                if (!pick_found && req[IDW'(idx)]) begin
                    pick_found = 1'b1;
                    pick       = IDW'(idx);
                end
            end
        end
    end
`else
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        for (int i = 1; i <= NVOICE; i++) begin
            int idx;
            idx = (int'(last_q) + i) % NVOICE;
            if (!pick_found && req[IDW'(idx)]) begin
                pick_found = 1'b1;
                pick       = IDW'(idx);
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        last_d   = last_q;
        ack_d    = '0;
        sample_d = sample_q;
        vid_d    = vid_q;
        case (state_q)
            IDLE: begin
                if (sr_q == 62'd0) begin
                    sr_d = SEED;
                end
                if (pick_found) begin
                    grant_d = pick;
                    cnt_d   = CW'(STEPS - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {sr_q[60:0], fb};
                cnt_d = cnt_q - 1'b1;
                // Load the outputs on the final step so they are valid during DELIVER.
                if (cnt_q == '0) begin
                    sample_d       = sr_d[DSZ-1:0];
                    vid_d          = grant_q;
                    ack_d[grant_q] = 1'b1;
                    state_d        = DELIVER;
                end
            end
            DELIVER: begin
`ifdef NOISE_SCHED_PRIO_EN
                if (grant_q != '0) begin
                    last_d = grant_q;
                end
`else
                last_d = grant_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sr_q     <= SEED;
            cnt_q    <= '0;
            grant_q  <= '0;
            last_q   <= IDW'(NVOICE - 1);
            ack_q    <= '0;
            sample_q <= '0;
            vid_q    <= '0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            sample_q <= sample_d;
            vid_q    <= vid_d;
        end
    end

    assign ack        = ack_q;
    assign sample     = sample_q;
    assign sample_vid = vid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_noise_voice_sched.sv
// Directed, scoreboard-based bench for noise_voice_sched with its default parameters.
// Define NOISE_SCHED_PRIO_EN for both files to exercise the fixed-priority variant.
module tb_noise_voice_sched;

    localparam logic [61:0] SEED  = 62'h36587D435AA26465;
    localparam int          STEPS = 18;

    typedef struct {
        int          vid;
        logic [17:0] smp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [17:0] sample;
    logic [1:0]  sample_vid;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [61:0] mdl;
    logic        sr_zero_seen = 1'b0;

    noise_voice_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .sample     (sample),
        .sample_vid (sample_vid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [61:0] lfsrAdvance(input logic [61:0] s, input int n);
        logic [61:0] r;
        r = s;
        for (int k = 0; k < n; k++) begin
            r = {r[60:0], r[61] ^ r[60] ^ r[5] ^ r[4]};
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input int vid);
        exp_t e;
        mdl   = lfsrAdvance(mdl, STEPS);
        e.vid = vid;
        e.smp = mdl[17:0];
        sb.push_back(e);
    endtask

    // Drive a request pattern; returns just after the edge where IDLE samples it.
    task automatic applyStimulus(input logic [3:0] r);
        @(posedge clk);
        #1 req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic waitAck(input int maxCyc, output int n, output logic busyBad);
        n       = 0;
        busyBad = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) busyBad = 1'b1;
        end while (ack === 4'b0000 && n < maxCyc);
        if (ack === 4'b0000) begin
            checkOutput("ack_timeout", 64'(n), 64'(maxCyc + 1));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl   = SEED;
    endtask

    // Scoreboard: every ack pops one expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (dut.state_q == 2'd0 && dut.sr_q == 62'd0) sr_zero_seen = 1'b1;
            if (ack !== 4'b0000) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("ack_onehot", 64'(ack), 64'(4'b0001 << e.vid));
                    checkOutput("sample_vid", 64'(sample_vid), 64'(e.vid));
                    checkOutput("sample", 64'(sample), 64'(e.smp));
                end
            end
        end
    end

    initial begin
        int          n;
        logic        bb;
        logic        bad;
        logic [17:0] held;
        logic [61:0] sr_held;

        rst_n = 1'b0;
        req   = 4'b0000;
        mdl   = SEED;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ack", 64'(ack), 64'd0);
        checkOutput("rst_sample", 64'(sample), 64'd0);
        checkOutput("rst_vid", 64'(sample_vid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sr", 64'(dut.sr_q), 64'(SEED));
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single voice 0 request");
        pushExp(0);
        applyStimulus(4'b0001);
        waitAck(40, n, bb);
        req = 4'b0000;
        checkOutput("t1_latency", 64'(n), 64'd19);
        checkOutput("t1_busy_in_service", 64'(bb), 64'd0);
        @(negedge clk);
        checkOutput("t1_busy_after", 64'(busy), 64'd0);
        checkOutput("t1_ack_one_cycle", 64'(ack), 64'd0);
        checkOutput("t1_sample_held", 64'(sample), 64'(lfsrAdvance(SEED, STEPS) & 62'h3FFFF));

        doReset();
`ifdef NOISE_SCHED_PRIO_EN
        $display("[TB] all voices requesting, voice 0 priority");
        for (int i = 0; i < 3; i++) pushExp(0);
        applyStimulus(4'b1111);
        waitAck(40, n, bb);
        checkOutput("t5_first_latency", 64'(n), 64'd19);
        for (int i = 0; i < 2; i++) begin
            waitAck(40, n, bb);
            checkOutput("t5_period", 64'(n), 64'd20);
        end
        req = 4'b1110;
        pushExp(1); pushExp(2); pushExp(3); pushExp(1);
        for (int i = 0; i < 4; i++) begin
            waitAck(40, n, bb);
            checkOutput("t5_rr_period", 64'(n), 64'd20);
        end
        req = 4'b0000;
`else
        $display("[TB] all voices requesting, round robin");
        for (int i = 0; i < 8; i++) pushExp(i % 4);
        applyStimulus(4'b1111);
        waitAck(40, n, bb);
        checkOutput("t2_first_latency", 64'(n), 64'd19);
        for (int i = 0; i < 7; i++) begin
            waitAck(40, n, bb);
            checkOutput("t2_period", 64'(n), 64'd20);
        end
        req = 4'b0000;
`endif

        $display("[TB] voice 2 single-cycle pulse");
        pushExp(2);
        applyStimulus(4'b0100);
        req = 4'b0000;
        waitAck(40, n, bb);
        checkOutput("t3_latency", 64'(n), 64'd19);
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (ack !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
        end
        checkOutput("t3_no_regrant", 64'(bad), 64'd0);

        $display("[TB] reset during shift");
        applyStimulus(4'b0001);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t4_ack", 64'(ack), 64'd0);
        checkOutput("t4_busy", 64'(busy), 64'd0);
        checkOutput("t4_state_idle", 64'(dut.state_q), 64'd0);
        checkOutput("t4_sr_seed", 64'(dut.sr_q), 64'(SEED));
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        mdl   = SEED;
        pushExp(0);
        applyStimulus(4'b0001);
        waitAck(40, n, bb);
        req = 4'b0000;
        checkOutput("t4_repeat_latency", 64'(n), 64'd19);
        @(negedge clk);

        $display("[TB] long idle");
        held    = sample;
        sr_held = dut.sr_q;
        bad     = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (ack !== 4'b0000 || busy !== 1'b0) bad = 1'b1;
        end
        checkOutput("t6_quiet", 64'(bad), 64'd0);
        checkOutput("t6_sample_held", 64'(sample), 64'(held));
        checkOutput("t6_sr_held", 64'(dut.sr_q), 64'(sr_held));
        checkOutput("lfsr_zero_seen", 64'(sr_zero_seen), 64'd0);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
